bram_pixel_streamer: RTL and testbench
======================================

# bram_pixel_streamer

Parametrised BRAM-to-stream pixel reader: on `start` it walks a stored image of `IMG_W`×`IMG_H` pixels in raster order out of a single-port block RAM and delivers them as a valid/ready pixel stream with start-of-frame, end-of-line and end-of-frame markers. It sits between the frame BRAM (`bram_new` class memory, 24-bit RGB words) and downstream image-processing stages. It supports:
- any BRAM read latency;
- downstream backpressure without losing pixels;
- optional continuous (looping) frame playback.

## Interface
- `DATA_W`, 24, pixel word width (RGB888).
- `ADDR_W`, 18, BRAM address width.
- `IMG_W`, 500, pixels per line, ≥2.
- `IMG_H`, 400, lines per frame, ≥1; `IMG_W*IMG_H` ≤ 2^`ADDR_W`.
- `BASE_ADDR`, 0, BRAM address of pixel (0,0).
- `RD_LAT`, 1, BRAM read latency in cycles, 1..4.
- `clka` in 1 single clock, all logic rising-edge.
- `rsta_n` in 1 asynchronous active-low reset.
- `start` in 1 one-cycle request; honoured only in IDLE.
- `loop` in 1 continuous playback enable; sampled at the last address issue of each frame.
- `busy` out 1 high from the cycle after accepted `start` until the final `done`.
- `done` out 1 one-cycle pulse when the last pixel of a frame is accepted downstream.
- `bram_en` out 1 BRAM read enable.
- `bram_addr` out `ADDR_W` BRAM read address.
- `bram_dout` in `DATA_W` BRAM read data, valid `RD_LAT` cycles after the `bram_en` cycle.
- `m_valid` out 1 stream data valid.
- `m_ready` in 1 stream ready from downstream.
- `m_data` out `DATA_W` pixel.
- `m_sof` out 1 qualifies pixel (0,0).
- `m_eol` out 1 qualifies the last pixel of each line.
- `m_eof` out 1 qualifies the last pixel of the frame.

Clock is `clka`; reset is asynchronous, active-low on `rsta_n`.

## Operation
**States**
- IDLE:
  - `start` → RUN.
  - Read counter and line/column tags cleared.
- RUN:
  - One read is issued per cycle while credit is available.
  - The issue address is `BASE_ADDR` + pixel index.
  - After the issue of index `IMG_W*IMG_H-1`:
    - if `loop`=1, the index wraps to 0 and the state stays in RUN;
    - otherwise the state → DRAIN.
- DRAIN:
  - No issues.
  - When the in-flight count and FIFO are both empty and the last pixel has been accepted → IDLE.

**Backpressure and credit**
- Internal FIFO depth D = `RD_LAT`+2, carrying `DATA_W`+3 bits (data plus sof/eol/eof tags).
- Tags are computed at issue time from the column/row counters and travel through an `RD_LAT`-deep tag pipe.
- Issue is allowed when `inflight + occupancy - pop` < D, where `pop` = `m_valid & m_ready`.
- Every returned word therefore always has a FIFO slot. An overflow condition is a design error and is asserted in simulation.

**Handshake**
- Transfer occurs when `m_valid & m_ready`.
- While `m_valid`=1 and `m_ready`=0, `m_data` and the tags are held stable.

**Frame completion**
- `done` pulses on the transfer carrying `m_eof`, in both single and loop modes.
- `busy` falls the cycle after the final `done` in non-loop operation.

**Boundary behaviour**
- `start` while not IDLE is ignored.
- Deasserting `loop` mid-frame: the current frame completes, then DRAIN.
- `IMG_H`=1: every `m_eol` pixel of the frame also carries `m_eof` on its last pixel.
- Counter widths are sized by `$clog2`; the address adder truncates to `ADDR_W`.

**Reset**
- Asynchronous reset, including mid-frame:
  - state → IDLE;
  - FIFO, in-flight counter, tag pipe and counters cleared;
  - data still returning from the BRAM after reset release is discarded.
- Reset values: `busy`=0, `done`=0, `bram_en`=0, `bram_addr`=0, `m_valid`=0, `m_data`=0, `m_sof`=0, `m_eol`=0, `m_eof`=0.

## Timing
- `bram_en` and `bram_addr` are registered.
- `start` sampled at cycle T:
  - `busy`=1 and first `bram_en` (address `BASE_ADDR`) in T+1;
  - first `m_valid` in T+2+`RD_LAT`.
- Throughput:
  - 1 pixel/cycle with `m_ready` held high;
  - a single-frame run with no stalls completes (`done`) at T+1+`RD_LAT`+`IMG_W*IMG_H`.
- After `m_ready` rises following a stall, `m_valid` stays high and data is delivered back to back; no bubble beyond the stall duration.
- In loop mode, no gap cycles between frames: the pixel after `m_eof` carries `m_sof`.

## Test plan
- **Basic frame:** `IMG_W`=4, `IMG_H`=2, `RD_LAT`=1, BRAM model returns `dout`=addr; start at T with `m_ready`=1.
  - `bram_en` from T+1; `m_valid` from T+3.
  - `m_data` 0..7 in consecutive cycles; `m_sof` on 0, `m_eol` on 3 and 7, `m_eof` on 7.
  - `done` with pixel 7; `busy` low next cycle.
- **Backpressure:** same image, `RD_LAT`=3, `m_ready` toggling 1,0,0,1 repeating.
  - Exactly 8 transfers, in order 0..7; no duplicates or drops.
  - Data held stable during stalls; in-flight+occupancy never exceeds 5.
- **Latency sweep:** `RD_LAT`=1..4, `BASE_ADDR`=100, `m_ready`=1.
  - First `m_data`=100 at T+2+`RD_LAT`; `done` at T+9+`RD_LAT`.
- **Loop:** `loop`=1 for three frames, then 0.
  - 24 contiguous transfers with `m_sof` on 0, 8 and 16.
  - Three `done` pulses, then IDLE.
- **Reset mid-frame:** assert `rsta_n`=0 after pixel 3 is transferred.
  - All outputs 0 immediately.
  - After release, a new `start` delivers a clean frame beginning with data 0 and `m_sof`.
- **Start while busy:** `start` pulsed during RUN and during DRAIN.
  - Ignored: exactly one frame delivered and one `done` pulse.

Source files
------------

// File: rtl/bram_pixel_streamer.sv
// Raster-order reader: walks an IMG_W x IMG_H image out of a single-port BRAM and
// presents it as a valid/ready pixel stream with sof/eol/eof markers.
module bram_pixel_streamer #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 18,
  parameter int IMG_W     = 500,
  parameter int IMG_H     = 400,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 1
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              start,
  input  logic              loop,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int DEPTH = RD_LAT + 2;
  localparam int IDX_W = $clog2(NPIX);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DATA_W + 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [2:0]       tag_p0;
  logic [RD_LAT-1:0] vld_p1;
  logic [2:0]       tag_p1 [RD_LAT];
  logic [CNT_W-1:0] inflight, occ;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [ENT_W-1:0] head;
  logic             last_idx, credit_ok, issue, wr, pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign last_idx = (idx == IDX_W'(NPIX - 1));
  assign wr       = vld_p1[RD_LAT-1];
  assign pop      = m_valid & m_ready;

  // Credit covers reads on the bus, reads in the latency pipe and FIFO entries,
  // so a returning word can never find the FIFO full.
  always_comb begin
    credit_ok = (int'(inflight) + int'(occ) - int'(pop)) < DEPTH;
    issue     = ((state == IDLE) && start) || ((state == RUN) && credit_ok);
  end

  // Stage p0: address issue and tag generation
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state     <= IDLE;
      idx       <= '0;
      col       <= '0;
      row       <= '0;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      tag_p0    <= '0;
    end else begin
      bram_en <= issue;
      if (issue) begin
        bram_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
        tag_p0    <= {(idx == '0), (col == COL_W'(IMG_W - 1)), last_idx};
        if (last_idx) begin
          idx <= '0;
          col <= '0;
          row <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
          if (col == COL_W'(IMG_W - 1)) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
      end
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (issue && last_idx && !loop) state <= DRAIN;
        DRAIN:   if ((inflight == '0) && ((occ == '0) || ((occ == CNT_W'(1)) && pop))) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: tags ride alongside the BRAM read latency
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      vld_p1   <= '0;
      inflight <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_p1[i] <= '0;
    end else begin
      vld_p1[0] <= bram_en;
      tag_p1[0] <= tag_p0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p1[i] <= vld_p1[i-1];
        tag_p1[i] <= tag_p1[i-1];
      end
      inflight <= inflight + CNT_W'(issue) - CNT_W'(wr);
    end
  end

  // Stage p2: skid FIFO feeding the stream
  always_ff @(posedge clka) begin
    if (wr) mem[wr_ptr] <= {bram_dout, tag_p1[RD_LAT-1]};
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr) wr_ptr <= ptr_next(wr_ptr);
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      occ <= occ + CNT_W'(wr) - CNT_W'(pop);
    end
  end

  assert property (@(posedge clka) disable iff (!rsta_n) !(wr && !pop && (occ == CNT_W'(DEPTH))));

  assign head    = mem[rd_ptr];
  assign m_valid = (occ != '0);
  assign m_data  = m_valid ? head[ENT_W-1:3] : '0;
  assign m_sof   = m_valid & head[2];
  assign m_eol   = m_valid & head[1];
  assign m_eof   = m_valid & head[0];
  assign done    = pop & m_eof;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_bram_pixel_streamer.sv
// Bench: four streamers (RD_LAT 1..4) on shared control, each scored against a
// frame-index model of raster order, markers, latency and handshake stability.
module tb_bram_pixel_streamer;
  localparam int DW = 24, AW = 18, W = 4, H = 2, N = W * H, NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, clr;
  logic ready = 1'b1;
  int   ready_mode = 0;
  bit   loop_on = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0] busy_a, done_a, en_a, valid_a, sof_a, eol_a, eof_a, loop_a;
  logic [AW-1:0] addr_a [NI];
  logic [DW-1:0] data_a [NI];
  logic [DW-1:0] dout_a [NI];

  int k_a [NI], xfers [NI], frames [NI], first_vld [NI], done_cyc [NI];
  int busy_fall [NI], first_x [NI], last_x [NI];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int LAT  = g + 1;
    localparam int BASE = (g == 0) ? 0 : 100;
    logic [DW-1:0] rd_p [LAT];

    assign loop_a[g] = loop_on && (frames[g] < 2);

    bram_pixel_streamer #(
      .DATA_W(DW), .ADDR_W(AW), .IMG_W(W), .IMG_H(H), .BASE_ADDR(BASE), .RD_LAT(LAT)
    ) dut (
      .clka(clk), .rsta_n(rst_n), .start(start), .loop(loop_a[g]),
      .busy(busy_a[g]), .done(done_a[g]), .bram_en(en_a[g]), .bram_addr(addr_a[g]),
      .bram_dout(dout_a[g]), .m_valid(valid_a[g]), .m_ready(ready), .m_data(data_a[g]),
      .m_sof(sof_a[g]), .m_eol(eol_a[g]), .m_eof(eof_a[g])
    );

    always @(posedge clk) begin
      rd_p[0] <= en_a[g] ? DW'(addr_a[g]) : 24'hBAD000;
      for (int i = 1; i < LAT; i++) rd_p[i] <= rd_p[i-1];
    end
    assign dout_a[g] = rd_p[LAT-1];

    initial begin
      logic          stall_q;
      logic          busy_q;
      logic [DW+2:0] held;
      stall_q = 1'b0;
      busy_q  = 1'b0;
      held    = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          k_a[g] = 0; stall_q = 1'b0; busy_q = 1'b0;
        end else if (clr) begin
          k_a[g] = 0; xfers[g] = 0; frames[g] = 0; first_vld[g] = -1; done_cyc[g] = -1;
          busy_fall[g] = -1; first_x[g] = -1; last_x[g] = -1;
          stall_q = 1'b0; busy_q = busy_a[g];
        end else begin
          if (stall_q) begin
            chk($sformatf("L%0d hold_valid", LAT), 64'(valid_a[g]), 64'd1);
            chk($sformatf("L%0d hold_data", LAT),
                64'({data_a[g], sof_a[g], eol_a[g], eof_a[g]}), 64'(held));
          end
          if (valid_a[g] && ready) begin
            chk($sformatf("L%0d data k=%0d", LAT, k_a[g]), 64'(data_a[g]), 64'(BASE + k_a[g]));
            chk($sformatf("L%0d tags k=%0d", LAT, k_a[g]), 64'({sof_a[g], eol_a[g], eof_a[g]}),
                64'({k_a[g] == 0, (k_a[g] % W) == W - 1, k_a[g] == N - 1}));
            chk($sformatf("L%0d done k=%0d", LAT, k_a[g]), 64'(done_a[g]), 64'(k_a[g] == N - 1));
            if (first_x[g] < 0) first_x[g] = cyc;
            last_x[g] = cyc;
            xfers[g]++;
            if (k_a[g] == N - 1) frames[g]++;
            k_a[g] = (k_a[g] + 1) % N;
          end else begin
            chk($sformatf("L%0d done_idle", LAT), 64'(done_a[g]), 64'd0);
          end
          if (valid_a[g] && first_vld[g] < 0) first_vld[g] = cyc;
          if (done_a[g]) done_cyc[g] = cyc;
          if (busy_q && !busy_a[g]) busy_fall[g] = cyc;
          stall_q = valid_a[g] && !ready;
          held    = {data_a[g], sof_a[g], eol_a[g], eof_a[g]};
          busy_q  = busy_a[g];
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: ready = ($urandom_range(2) != 0);
      endcase
    end
  end

  task automatic chk_zero(input string tag);
    for (int g = 0; g < NI; g++)
      chk($sformatf("%s L%0d", tag, g + 1),
          64'({busy_a[g], done_a[g], en_a[g], addr_a[g], valid_a[g], data_a[g],
               sof_a[g], eol_a[g], eof_a[g]}), 64'd0);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Pulses start, checks the first issue cycle, then waits (bounded) for all to idle.
  task automatic run_frame(input int mode, input bit pokes, output int t0);
    int base;
    ready_mode = mode;
    do_clear();
    t0 = cyc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int g = 0; g < NI; g++) begin
      base = (g == 0) ? 0 : 100;
      chk($sformatf("first_issue L%0d", g + 1), 64'({busy_a[g], en_a[g], addr_a[g]}),
          64'({1'b1, 1'b1, AW'(base)}));
    end
    for (int i = 0; i < 400; i++) begin
      if (busy_a == '0) break;
      start = pokes && (&busy_a) && ($urandom_range(2) == 0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("idle_within_budget", 64'(busy_a), 64'd0);
    repeat (5) @(posedge clk);
    #1 chk("stays_idle", 64'(busy_a), 64'd0);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0;
    start = 1'b0;
    clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame and latency sweep with continuous ready.
    run_frame(0, 1'b0, t0);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("first_valid L%0d", g + 1), 64'(first_vld[g]), 64'(t0 + 3 + g));
      chk($sformatf("done_cycle L%0d", g + 1), 64'(done_cyc[g]), 64'(t0 + 10 + g));
      chk($sformatf("busy_fall L%0d", g + 1), 64'(busy_fall[g]), 64'(t0 + 11 + g));
      chk($sformatf("contiguous L%0d", g + 1), 64'(last_x[g] - first_x[g]), 64'(N - 1));
      chk($sformatf("count L%0d", g + 1), 64'({xfers[g], frames[g]}), 64'({32'(N), 32'd1}));
    end

    // Backpressure pattern 1,0,0,1 with start pokes during RUN and DRAIN.
    run_frame(1, 1'b1, t0);
    for (int g = 0; g < NI; g++)
      chk($sformatf("bp_count L%0d", g + 1), 64'({xfers[g], frames[g]}), 64'({32'(N), 32'd1}));

    // Three looped frames, then loop released.
    loop_on = 1'b1;
    run_frame(0, 1'b0, t0);
    loop_on = 1'b0;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("loop_count L%0d", g + 1), 64'({xfers[g], frames[g]}),
          64'({32'(3 * N), 32'd3}));
      chk($sformatf("loop_contig L%0d", g + 1), 64'(last_x[g] - first_x[g]), 64'(3 * N - 1));
    end

    // Random ready with random start pokes.
    for (int r = 0; r < 3; r++) begin
      run_frame(2, 1'b1, t0);
      for (int g = 0; g < NI; g++)
        chk($sformatf("rand%0d_count L%0d", r, g + 1), 64'({xfers[g], frames[g]}),
            64'({32'(N), 32'd1}));
    end

    // Reset mid-frame after pixel 3 of the RD_LAT=1 streamer.
    ready_mode = 0;
    do_clear();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (xfers[0] >= 4) break;
      @(posedge clk);
      #1;
    end
    chk("mid_frame_reached", 64'(xfers[0]), 64'd4);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(0, 1'b0, t0);
    for (int g = 0; g < NI; g++)
      chk($sformatf("post_reset L%0d", g + 1), 64'({xfers[g], frames[g]}), 64'({32'(N), 32'd1}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
